// File: rtl/instruction_encoder_writer.sv
// Purpose: packs R/I/J field sets into 32-bit words and streams them into instruction memory at auto-incrementing addresses.
// Latency: an accepted word can reach mem_data one cycle after the input transfer at the earliest; the FIFO has no bypass path.
// Backpressure: in_ready drops when the DEPTH-entry FIFO is full; mem_ready=0 holds the head word and its address stable.
module instruction_encoder_writer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_fmt,
  input  logic [4:0]            in_opcode,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_shamt,
  input  logic [4:0]            in_aluop,
  input  logic [16:0]           in_imm,
  input  logic [26:0]           in_target,
  input  logic                  load_addr,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  err_illegal,
  input  logic                  clr_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(DEPTH);

  logic [31:0]           fifo_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        occ_q, occ_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic                  err_q, err_d;

  logic [31:0] enc_word;
  logic        xfer, push, pop, illegal;

  assign in_ready    = (occ_q != FULL_OCC);
  assign mem_we      = (occ_q != '0);
  // Empty FIFO presents zero rather than whatever stale word sits at the read pointer.
  assign mem_data    = mem_we ? fifo_q[rd_ptr_q] : 32'd0;
  assign mem_addr    = addr_q;
  assign count       = count_q;
  assign err_illegal = err_q;

  assign xfer    = in_valid & in_ready;
  assign push    = xfer & (in_fmt != 2'b11);
  assign illegal = xfer & (in_fmt == 2'b11);
  assign pop     = mem_we & mem_ready;

  // Field packing for the three legal formats; the illegal code never gets pushed.
  always_comb begin
    enc_word = 32'd0;
    unique case (in_fmt)
      2'b00:   enc_word = {in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop, 2'b00};
      2'b01:   enc_word = {in_opcode, in_rd, in_rs, in_imm};
      2'b10:   enc_word = {in_opcode, in_target};
      default: enc_word = 32'd0;
    endcase
  end

  // Next-state for pointers, occupancy, write address, completion count and error flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    addr_d   = addr_q;
    count_d  = count_q;
    err_d    = err_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    // The completing word already used addr_q; a load on the same edge overrides the increment.
    if (pop)       addr_d = addr_q + 1'b1;
    if (load_addr) addr_d = start_addr;

    if (pop && (count_q != '1)) count_d = count_q + 1'b1;

    // A new illegal transfer outranks a simultaneous clear.
    if (clr_err) err_d = 1'b0;
    if (illegal) err_d = 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      addr_q   <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage; only the slot at the write pointer changes on a push.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= 32'd0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= enc_word;
    end
  end

endmodule

// File: tb/tb_instruction_encoder_writer.sv
// Bench for instruction_encoder_writer: directed field sets with hand-computed words,
// expected writes queued at issue time and retired by an independent write monitor.
module tb_instruction_encoder_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_fmt = 2'b00;
  logic [4:0]  in_opcode = '0, in_rd = '0, in_rs = '0, in_rt = '0, in_shamt = '0, in_aluop = '0;
  logic [16:0] in_imm = '0;
  logic [26:0] in_target = '0;
  logic        load_addr = 1'b0;
  logic [11:0] start_addr = '0;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ready = 1'b0;
  logic [11:0] count;
  logic        err_illegal;
  logic        clr_err = 1'b0;

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  instruction_encoder_writer #(.DEPTH(4), .ADDR_WIDTH(12)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_shamt(in_shamt), .in_aluop(in_aluop), .in_imm(in_imm), .in_target(in_target),
    .load_addr(load_addr), .start_addr(start_addr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .count(count), .err_illegal(err_illegal), .clr_err(clr_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completed memory write must match the oldest expected entry.
  always @(negedge clock) begin
    if (reset && mem_we && mem_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr, mem_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", {20'd0, mem_addr}, {20'd0, e.a});
        chk("wr_data", mem_data, e.d);
      end
    end
  end

  // Present one field set and hold it until accepted; legal ones queue their expected write.
  task automatic send(input logic [1:0] fmt, input logic [4:0] op, rd, rs, rt, sh, alu,
                      input logic [16:0] imm, input logic [26:0] tgt, input logic clr,
                      input logic [11:0] ea, input logic [31:0] ed);
    int n;
    wr_t e;
    @(posedge clock); #1;
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt;
    in_shamt = sh; in_aluop = alu; in_imm = imm; in_target = tgt;
    in_valid = 1'b1; clr_err = clr;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 for 100 cycles, expected 1");
    end else begin
      if (fmt != 2'b11) begin
        e.a = ea;
        e.d = ed;
        sb.push_back(e);
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    clr_err  = 1'b0;
  endtask

  task automatic send_j(input logic [4:0] op, input logic [26:0] tgt,
                        input logic [11:0] ea, input logic [31:0] ed);
    send(2'b10, op, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, tgt, 1'b0, ea, ed);
  endtask

  task automatic load(input logic [11:0] a);
    @(posedge clock); #1;
    load_addr = 1'b1; start_addr = a;
    @(posedge clock); #1;
    load_addr = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || mem_we) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (sb.size() != 0 || mem_we) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending writes, mem_we %b, expected 0 and 0", sb.size(), mem_we);
    end
  endtask

  initial begin
    // Reset state while reset is held low.
    #12;
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
    chk("rst_mem_data", mem_data, 32'd0);
    chk("rst_count", {20'd0, count}, 32'd0);
    chk("rst_err", {31'd0, err_illegal}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Single R-type word.
    mem_ready = 1'b1;
    send(2'b00, 5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 17'd0, 27'd0, 1'b0, 12'h000, 32'h00C2_2000);
    drain();
    chk("r_count", {20'd0, count}, 32'd1);

    // I then J, in order, from address 0.
    load(12'h000);
    send(2'b01, 5'd5, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd5, 27'd0, 1'b0, 12'h000, 32'h2840_0005);
    send_j(5'd1, 27'h10, 12'h001, 32'h0800_0010);
    drain();
    chk("ij_count", {20'd0, count}, 32'd3);

    // Backpressure: fill with mem_ready low, check hold, then release.
    load(12'h000);
    mem_ready = 1'b0;
    for (int k = 1; k <= 4; k++)
      send_j(5'd3, 27'h100 + 27'(k), 12'(k - 1), 32'h1800_0100 + 32'(k));
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("hold_we", {31'd0, mem_we}, 32'd1);
      chk("hold_addr", {20'd0, mem_addr}, 32'd0);
      chk("hold_data", mem_data, 32'h1800_0101);
    end
    fork
      send_j(5'd3, 27'h105, 12'h004, 32'h1800_0105);
      begin
        repeat (3) @(posedge clock);
        #1 mem_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", {20'd0, count}, 32'd8);

    // Address wrap from all-ones.
    load(12'hFFF);
    chk("load_addr", {20'd0, mem_addr}, 32'h0000_0FFF);
    send_j(5'd7, 27'h1, 12'hFFF, 32'h3800_0001);
    send_j(5'd7, 27'h2, 12'h000, 32'h3800_0002);
    drain();
    chk("wrap_addr", {20'd0, mem_addr}, 32'd1);
    chk("wrap_count", {20'd0, count}, 32'd10);

    // Illegal format: consumed, not written, sticky flag; set beats clear.
    send(2'b11, 5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 17'd9, 27'd9, 1'b0, 12'h000, 32'd0);
    chk("ill_err", {31'd0, err_illegal}, 32'd1);
    chk("ill_no_we", {31'd0, mem_we}, 32'd0);
    send(2'b11, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 17'd1, 27'd1, 1'b1, 12'h000, 32'd0);
    chk("ill_set_wins", {31'd0, err_illegal}, 32'd1);
    @(posedge clock); #1 clr_err = 1'b1;
    @(posedge clock); #1 clr_err = 1'b0;
    chk("clr_err", {31'd0, err_illegal}, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    chk("ill_count", {20'd0, count}, 32'd10);

    // Reset with three queued words: immediate clear, nothing written afterwards.
    mem_ready = 1'b0;
    send_j(5'd2, 27'h21, 12'h001, 32'h1000_0021);
    send_j(5'd2, 27'h22, 12'h002, 32'h1000_0022);
    send_j(5'd2, 27'h23, 12'h003, 32'h1000_0023);
    chk("pre_rst_we", {31'd0, mem_we}, 32'd1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
    chk("mid_rst_count", {20'd0, count}, 32'd0);
    chk("mid_rst_addr", {20'd0, mem_addr}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    mem_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    chk("post_rst_we", {31'd0, mem_we}, 32'd0);
    chk("post_rst_count", {20'd0, count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
